// File: rtl/mem_bus_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto a single-outstanding system bus.
// Data side has priority; a starvation counter forces the fetch side through after repeated losses.
module mem_bus_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_read_en,
  output logic [DATA_WIDTH-1:0] imem_read_data,
  output logic                  imem_ready,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_write_data,
  input  logic                  dmem_read_en,
  input  logic                  dmem_write_en,
  output logic [DATA_WIDTH-1:0] dmem_read_data,
  output logic                  dmem_ready,
  output logic                  bus_valid,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_write,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ack,
  output logic                  bus_timeout,
  output logic [7:0]            timeout_count,
  output logic [1:0]            o_dbg_state
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUS_I = 2'd1,
    S_BUS_D = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [SW-1:0]         r_starve;
  logic [TW-1:0]         r_tcnt;
  logic                  r_is_d;
  logic                  r_timed_out;
  logic                  r_bus_valid;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic                  r_bus_write;
  logic [DATA_WIDTH-1:0] r_bus_wdata;
  logic [DATA_WIDTH-1:0] r_imem_rdata;
  logic [DATA_WIDTH-1:0] r_dmem_rdata;
  logic [7:0]            r_tmo_count;

  logic w_d_req;
  logic w_starved;
  logic w_grant_i;
  logic w_grant_d;
  logic w_in_bus;
  logic w_ack_hit;
  logic w_tmo_hit;

  // Handshake: requesters hold their level request until their one-cycle ready pulse;
  // bus_valid and its payload stay stable from grant until bus_ack (single cycle) or timeout.
  assign w_d_req   = dmem_read_en | dmem_write_en;
  assign w_starved = imem_read_en && (r_starve == SW'(STARVE_LIMIT));
  assign w_grant_i = (r_state == S_IDLE) && imem_read_en && (!w_d_req || w_starved);
  assign w_grant_d = (r_state == S_IDLE) && w_d_req && !w_grant_i;
  assign w_in_bus  = (r_state == S_BUS_I) || (r_state == S_BUS_D);
  assign w_ack_hit = w_in_bus && bus_ack;
  // An ack arriving on the final cycle wins over the timeout.
  assign w_tmo_hit = w_in_bus && !bus_ack && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_i)      w_next_state = S_BUS_I;
        else if (w_grant_d) w_next_state = S_BUS_D;
      end
      S_BUS_I, S_BUS_D: begin
        if (w_ack_hit || w_tmo_hit) w_next_state = S_RESP;
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    imem_ready  = 1'b0;
    dmem_ready  = 1'b0;
    bus_timeout = 1'b0;
    if (r_state == S_RESP) begin
      imem_ready  = !r_is_d;
      dmem_ready  = r_is_d;
      bus_timeout = r_timed_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve     <= '0;
      r_tcnt       <= '0;
      r_is_d       <= 1'b0;
      r_timed_out  <= 1'b0;
      r_bus_valid  <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_write  <= 1'b0;
      r_bus_wdata  <= '0;
      r_imem_rdata <= '0;
      r_dmem_rdata <= '0;
      r_tmo_count  <= '0;
    end else begin
      if (w_grant_i) begin
        r_bus_valid <= 1'b1;
        r_bus_addr  <= imem_addr;
        r_bus_write <= 1'b0;
        r_bus_wdata <= '0;
        r_is_d      <= 1'b0;
        r_tcnt      <= '0;
        r_timed_out <= 1'b0;
        r_starve    <= '0;
      end else if (w_grant_d) begin
        r_bus_valid <= 1'b1;
        r_bus_addr  <= dmem_addr;
        r_bus_write <= dmem_write_en;
        r_bus_wdata <= dmem_write_en ? dmem_write_data : '0;
        r_is_d      <= 1'b1;
        r_tcnt      <= '0;
        r_timed_out <= 1'b0;
        if (!imem_read_en)                        r_starve <= '0;
        else if (r_starve != SW'(STARVE_LIMIT))   r_starve <= r_starve + SW'(1);
      end else if (r_state == S_IDLE) begin
        r_starve <= '0;
      end

      if (w_ack_hit) begin
        r_bus_valid <= 1'b0;
        if (!r_bus_write) begin
          if (r_is_d) r_dmem_rdata <= bus_rdata;
          else        r_imem_rdata <= bus_rdata;
        end
      end else if (w_tmo_hit) begin
        r_bus_valid <= 1'b0;
        r_timed_out <= 1'b1;
        if (r_is_d) r_dmem_rdata <= '0;
        else        r_imem_rdata <= '0;
        if (r_tmo_count != 8'hFF) r_tmo_count <= r_tmo_count + 8'd1;
      end else if (w_in_bus) begin
        r_tcnt <= r_tcnt + TW'(1);
      end
    end
  end

  assign bus_valid      = r_bus_valid;
  assign bus_addr       = r_bus_addr;
  assign bus_write      = r_bus_write;
  assign bus_wdata      = r_bus_wdata;
  assign imem_read_data = r_imem_rdata;
  assign dmem_read_data = r_dmem_rdata;
  assign timeout_count  = r_tmo_count;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: latency, write path, starvation, timeout, reset abort.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_read_en;
  logic [31:0] imem_read_data;
  logic        imem_ready;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_write_data;
  logic        dmem_read_en;
  logic        dmem_write_en;
  logic [31:0] dmem_read_data;
  logic        dmem_ready;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic        bus_write;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_timeout;
  logic [7:0]  timeout_count;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_read_en    (imem_read_en),
    .imem_read_data  (imem_read_data),
    .imem_ready      (imem_ready),
    .dmem_addr       (dmem_addr),
    .dmem_write_data (dmem_write_data),
    .dmem_read_en    (dmem_read_en),
    .dmem_write_en   (dmem_write_en),
    .dmem_read_data  (dmem_read_data),
    .dmem_ready      (dmem_ready),
    .bus_valid       (bus_valid),
    .bus_addr        (bus_addr),
    .bus_write       (bus_write),
    .bus_wdata       (bus_wdata),
    .bus_rdata       (bus_rdata),
    .bus_ack         (bus_ack),
    .bus_timeout     (bus_timeout),
    .timeout_count   (timeout_count),
    .o_dbg_state     (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    imem_addr = '0; imem_read_en = 1'b0;
    dmem_addr = '0; dmem_write_data = '0; dmem_read_en = 1'b0; dmem_write_en = 1'b0;
    bus_rdata = '0; bus_ack = 1'b0;
    step();
    step();
    check("rst_bus_valid", bus_valid, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_write", bus_write, 0);
    check("rst_imem_ready", imem_ready, 0);
    check("rst_dmem_ready", dmem_ready, 0);
    check("rst_bus_timeout", bus_timeout, 0);
    check("rst_timeout_count", timeout_count, 0);
    check("rst_imem_rdata", imem_read_data, 0);
    check("rst_dmem_rdata", dmem_read_data, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;

    // imem read, minimum latency
    imem_addr = 32'h100; imem_read_en = 1'b1;
    step();
    check("i_bus_valid_n1", bus_valid, 1);
    check("i_bus_addr", bus_addr, 32'h100);
    check("i_bus_write", bus_write, 0);
    check("i_bus_wdata", bus_wdata, 0);
    check("i_ready_early", imem_ready, 0);
    bus_ack = 1'b1; bus_rdata = 32'hE3A00001;
    step();
    check("i_ready_n2", imem_ready, 1);
    check("i_dready_n2", dmem_ready, 0);
    check("i_rdata", imem_read_data, 32'hE3A00001);
    check("i_bus_valid_drop", bus_valid, 0);
    bus_ack = 1'b0;
    step();
    imem_read_en = 1'b0;
    check("i_ready_pulse", imem_ready, 0);

    // ack while idle is ignored
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    step();
    check("idle_ack_irdata", imem_read_data, 32'hE3A00001);
    check("idle_ack_drdata", dmem_read_data, 0);
    check("idle_ack_valid", bus_valid, 0);
    bus_ack = 1'b0;

    // dmem write with delayed ack
    dmem_addr = 32'h2000; dmem_write_data = 32'hCAFEF00D; dmem_write_en = 1'b1;
    step();
    check("w_bus_valid", bus_valid, 1);
    check("w_bus_write", bus_write, 1);
    check("w_bus_wdata", bus_wdata, 32'hCAFEF00D);
    check("w_bus_addr", bus_addr, 32'h2000);
    step();
    check("w_hold_valid", bus_valid, 1);
    check("w_hold_wdata", bus_wdata, 32'hCAFEF00D);
    check("w_no_ready", dmem_ready, 0);
    bus_ack = 1'b1; bus_rdata = 32'h12345678;
    step();
    check("w_dready", dmem_ready, 1);
    check("w_iready", imem_ready, 0);
    check("w_drdata_same", dmem_read_data, 0);
    bus_ack = 1'b0;
    step();
    dmem_write_en = 1'b0;
    check("w_dready_once", dmem_ready, 0);

    // read+write together is a write
    dmem_addr = 32'h3000; dmem_write_data = 32'h55; dmem_read_en = 1'b1; dmem_write_en = 1'b1;
    step();
    check("rw_bus_write", bus_write, 1);
    check("rw_bus_wdata", bus_wdata, 32'h55);
    bus_ack = 1'b1; bus_rdata = 32'hAAAA;
    step();
    check("rw_dready", dmem_ready, 1);
    check("rw_drdata_same", dmem_read_data, 0);
    bus_ack = 1'b0;
    step();
    dmem_read_en = 1'b0; dmem_write_en = 1'b0;

    // starvation: dmem wins four times, imem takes the fifth
    imem_addr = 32'h400; imem_read_en = 1'b1;
    dmem_addr = 32'h500; dmem_read_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("st_bus_addr", bus_addr, (k < 4) ? 32'h500 : 32'h400);
      bus_ack = 1'b1; bus_rdata = 32'h10 + k;
      step();
      check("st_dready", dmem_ready, (k < 4) ? 1 : 0);
      check("st_iready", imem_ready, (k < 4) ? 0 : 1);
      bus_ack = 1'b0;
      step();
    end
    imem_read_en = 1'b0; dmem_read_en = 1'b0;
    check("st_drdata", dmem_read_data, 32'h13);
    check("st_irdata", imem_read_data, 32'h14);

    // dmem read timeout
    dmem_addr = 32'h6000; dmem_read_en = 1'b1;
    step();
    check("to_valid_first", bus_valid, 1);
    repeat (254) step();
    check("to_valid_last", bus_valid, 1);
    check("to_no_ready", dmem_ready, 0);
    step();
    check("to_valid_drop", bus_valid, 0);
    check("to_dready", dmem_ready, 1);
    check("to_pulse", bus_timeout, 1);
    check("to_drdata", dmem_read_data, 0);
    check("to_count", timeout_count, 1);
    step();
    dmem_read_en = 1'b0;
    check("to_pulse_end", bus_timeout, 0);
    check("to_dready_end", dmem_ready, 0);

    // ack on the final cycle wins over the timeout
    dmem_addr = 32'h6100; dmem_read_en = 1'b1;
    step();
    repeat (254) step();
    bus_ack = 1'b1; bus_rdata = 32'hBEEF;
    step();
    check("ta_dready", dmem_ready, 1);
    check("ta_no_timeout", bus_timeout, 0);
    check("ta_drdata", dmem_read_data, 32'hBEEF);
    check("ta_count", timeout_count, 1);
    bus_ack = 1'b0;
    step();
    dmem_read_en = 1'b0;

    // reset mid-transaction, then pending imem is served
    dmem_addr = 32'h7000; dmem_read_en = 1'b1;
    imem_addr = 32'h800; imem_read_en = 1'b1;
    step();
    check("rm_bus_addr", bus_addr, 32'h7000);
    check("rm_bus_valid", bus_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rm_valid_async", bus_valid, 0);
    check("rm_state_async", dbg_state, 0);
    step();
    check("rm_no_dready", dmem_ready, 0);
    check("rm_no_iready", imem_ready, 0);
    check("rm_count_clr", timeout_count, 0);
    check("rm_drdata_clr", dmem_read_data, 0);
    dmem_read_en = 1'b0;
    rst = 1'b0;
    step();
    check("rm_i_valid", bus_valid, 1);
    check("rm_i_addr", bus_addr, 32'h800);
    check("rm_i_write", bus_write, 0);
    bus_ack = 1'b1; bus_rdata = 32'h0BADC0DE;
    step();
    check("rm_i_ready", imem_ready, 1);
    check("rm_d_ready", dmem_ready, 0);
    check("rm_i_rdata", imem_read_data, 32'h0BADC0DE);
    bus_ack = 1'b0;
    step();
    imem_read_en = 1'b0;
    check("rm_idle", dbg_state, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of all data paths.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: width of all addresses.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4: consecutive lost imem arbitrations before imem is forced to win.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255: bus cycles without bus_ack before a transaction is aborted.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port imem_addr  in  ADDR_WIDTH  instruction fetch address.
REQ-008 SHALL have port imem_read_en  in  1  fetch request, level, held until imem_ready.
REQ-009 SHALL have port imem_read_data  out  DATA_WIDTH  fetched word.
REQ-010 SHALL have port imem_ready  out  1  one-cycle fetch completion pulse.
REQ-011 SHALL have port dmem_addr  in  ADDR_WIDTH  data address.
REQ-012 SHALL have port dmem_write_data  in  DATA_WIDTH  store data.
REQ-013 SHALL have port dmem_read_en  in  1  load request, level.
REQ-014 SHALL have port dmem_write_en  in  1  store request, level.
REQ-015 SHALL have port dmem_read_data  out  DATA_WIDTH  loaded word.
REQ-016 SHALL have port dmem_ready  out  1  one-cycle data completion pulse.
REQ-017 SHALL have port bus_valid  out  1  system bus request, held until ack or timeout.
REQ-018 SHALL have port bus_addr  out  ADDR_WIDTH  system bus address.
REQ-019 SHALL have port bus_write  out  1  1 = write, 0 = read.
REQ-020 SHALL have port bus_wdata  out  DATA_WIDTH  system bus write data.
REQ-021 SHALL have port bus_rdata  in  DATA_WIDTH  system bus read data, valid with bus_ack.
REQ-022 SHALL have port bus_ack  in  1  system bus completion, single cycle.
REQ-023 SHALL have port bus_timeout  out  1  one-cycle pulse on aborted transaction.
REQ-024 SHALL have port timeout_count  out  8  saturating count of aborted transactions.

Function
REQ-025 SHALL implement FSM states IDLE, BUS_I, BUS_D, RESP; at most one bus transaction outstanding.
REQ-026 In IDLE, SHALL grant dmem if dmem_read_en|dmem_write_en, else imem if imem_read_en, else stay IDLE; exception: imem wins if both request and starve counter == STARVE_LIMIT.
REQ-027 Starve counter SHALL increment (saturating at STARVE_LIMIT) when imem requests but dmem is granted, and clear when imem is granted or imem_read_en is low in IDLE.
REQ-028 On grant, SHALL register address, direction and write data; bus_valid, bus_addr, bus_write, bus_wdata SHALL be registered outputs asserted the cycle after the grant and held stable until the transaction ends.
REQ-029 dmem_read_en and dmem_write_en both high SHALL be treated as a write; imem transactions SHALL always be reads; bus_wdata SHALL be 0 for reads.
REQ-030 On bus_ack high in BUS_I/BUS_D, SHALL capture bus_rdata into the granted port's read_data register (writes leave it unchanged), deassert bus_valid next cycle, and enter RESP.
REQ-031 In RESP, SHALL assert exactly one of imem_ready/dmem_ready for one cycle, then return to IDLE; requester drops its request in the cycle after ready.
REQ-032 Minimum latency: request high in cycle N, bus_valid in N+1, bus_ack in N+1, ready in N+2.
REQ-033 imem_read_data and dmem_read_data SHALL hold their last captured value until next capture for that port.
REQ-034 Timeout counter SHALL count cycles in BUS_I/BUS_D; on reaching TIMEOUT_CYCLES without ack, SHALL drop bus_valid, load 0 into the granted port's read_data, pulse bus_timeout in the RESP cycle, increment timeout_count (saturate at 255), and complete via RESP.
REQ-035 bus_ack while in IDLE or RESP SHALL be ignored.
REQ-036 bus_ack on the same cycle the timeout is reached SHALL be treated as a normal ack (no timeout).

Reset
REQ-037 rst high SHALL asynchronously force state IDLE; bus_valid, bus_write, imem_ready, dmem_ready, bus_timeout to 0; bus_addr, bus_wdata, read_data registers, starve counter, timeout counter, timeout_count to 0.
REQ-038 Reset mid-transaction SHALL abort without issuing any ready pulse; first grant is evaluated in the first clk edge after rst deasserts.

Verification
REQ-039 imem read 0x100, ack next cycle with 0xE3A00001 -> bus_valid cycle N+1, imem_ready cycle N+2, imem_read_data = 0xE3A00001.
REQ-040 dmem write 0x2000 data 0xCAFEF00D -> bus_write=1, bus_wdata=0xCAFEF00D, dmem_ready once, dmem_read_data unchanged.
REQ-041 imem and dmem requesting continuously, dmem re-requesting every completion -> dmem granted 4 times, then imem granted on 5th arbitration.
REQ-042 dmem read, bus_ack never asserted -> bus_valid drops after 255 cycles, dmem_ready and bus_timeout pulse together, dmem_read_data = 0, timeout_count = 1.
REQ-043 rst asserted while bus_valid high in BUS_D -> bus_valid 0 immediately, no dmem_ready, after release a pending imem request is granted normally.
